// File: rtl/mem_arbiter.sv
// Serialises I-cache fills, D-cache fills and D-side write-through onto one
// multi-cycle memory: pipelined 8-word block reads, single-word writes.
module mem_arbiter #(
    parameter int unsigned MEM_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_miss,
    input  logic [15:0] i_miss_addr,
    output logic        i_fill_we,
    output logic        i_fill_grant,
    output logic        i_fill_done,
    input  logic        d_miss,
    input  logic [15:0] d_miss_addr,
    output logic        d_fill_we,
    output logic        d_fill_grant,
    output logic        d_fill_done,
    input  logic        d_wr,
    input  logic [15:0] d_wr_addr,
    input  logic [15:0] d_wr_data,
    output logic        d_wr_done,
    output logic [2:0]  fill_word,
    output logic [15:0] fill_data,
    output logic [15:0] mem_addr,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_valid
);
    localparam int unsigned WORDS  = 8;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned BASE_W = 12;
    localparam bit          LAT_OK = (MEM_LAT >= 1) && (MEM_LAT <= 8);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        GAP   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]   rx_cnt_q, rx_cnt_d;
    logic [BASE_W-1:0]  base_q, base_d;
    logic               owner_d_q, owner_d_d;   // 1: D-cache owns the fill

    // Line-offset bits of the miss addresses are never used.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_miss_addr[3:0], d_miss_addr[3:0]};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            rx_cnt_q    <= '0;
            base_q      <= '0;
            owner_d_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            base_q      <= base_d;
            owner_d_q   <= owner_d_d;
        end
    end

    // Next state and output decode
    always_comb begin
        state_d      = state_q;
        issue_cnt_d  = issue_cnt_q;
        rx_cnt_d     = rx_cnt_q;
        base_d       = base_q;
        owner_d_d    = owner_d_q;
        i_fill_we    = 1'b0;
        i_fill_grant = 1'b0;
        i_fill_done  = 1'b0;
        d_fill_we    = 1'b0;
        d_fill_grant = 1'b0;
        d_fill_done  = 1'b0;
        d_wr_done    = 1'b0;
        fill_word    = '0;
        fill_data    = '0;
        mem_addr     = '0;
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_wdata    = '0;

        case (state_q)
            IDLE: begin
                if (d_wr) begin
                    state_d = WRITE;
                end else if (d_miss || i_miss) begin
                    state_d     = FILL;
                    owner_d_d   = d_miss;
                    base_d      = d_miss ? d_miss_addr[15:4] : i_miss_addr[15:4];
                    issue_cnt_d = '0;
                    rx_cnt_d    = '0;
                end
            end
            FILL: begin
                i_fill_grant = !owner_d_q;
                d_fill_grant = owner_d_q;
                if (issue_cnt_q < CNT_W'(WORDS)) begin
                    mem_en      = 1'b1;
                    mem_addr    = {base_q, issue_cnt_q[2:0], 1'b0};
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                end
                // Returned words are steered by arrival order, not by address.
                if (mem_valid && (rx_cnt_q < CNT_W'(WORDS))) begin
                    fill_word = rx_cnt_q[2:0];
                    fill_data = mem_rdata;
                    i_fill_we = !owner_d_q;
                    d_fill_we = owner_d_q;
                    rx_cnt_d  = rx_cnt_q + CNT_W'(1);
                    if (rx_cnt_q == CNT_W'(WORDS - 1)) begin
                        i_fill_done = !owner_d_q;
                        d_fill_done = owner_d_q;
                        state_d     = GAP;
                    end
                end
            end
            WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = d_wr_addr;
                mem_wdata = d_wr_data;
                d_wr_done = 1'b1;
                state_d   = GAP;
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory must never return more words than were requested.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (LAT_OK);
            if (state_q == FILL && mem_valid) begin
                assert (rx_cnt_q < CNT_W'(WORDS));
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter against a cycle-accurate
// transaction model derived from the arbitration and fill timing rules.
module tb_mem_arbiter;
    localparam int unsigned MEM_LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_miss, d_miss, d_wr;
    logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
    logic        i_fill_we, i_fill_grant, i_fill_done;
    logic        d_fill_we, d_fill_grant, d_fill_done, d_wr_done;
    logic [2:0]  fill_word;
    logic [15:0] fill_data, mem_addr, mem_wdata, mem_rdata;
    logic        mem_en, mem_wr, mem_valid;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr),
        .i_fill_we(i_fill_we), .i_fill_grant(i_fill_grant), .i_fill_done(i_fill_done),
        .d_miss(d_miss), .d_miss_addr(d_miss_addr),
        .d_fill_we(d_fill_we), .d_fill_grant(d_fill_grant), .d_fill_done(d_fill_done),
        .d_wr(d_wr), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data), .d_wr_done(d_wr_done),
        .fill_word(fill_word), .fill_data(fill_data),
        .mem_addr(mem_addr), .mem_en(mem_en), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid)
    );

    typedef struct packed {
        logic        mem_en;
        logic        mem_wr;
        logic [15:0] mem_addr;
        logic [15:0] mem_wdata;
        logic        i_we, i_grant, i_done;
        logic        d_we, d_grant, d_done;
        logic        wr_done;
        logic [2:0]  word;
        logic [15:0] data;
    } obs_t;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          lat = 4;          // memory-model latency; the arbiter itself is latency-agnostic
    int          next_arb = 0;     // model: next cycle in which the arbiter is in IDLE
    int          i_we_cnt = 0, d_we_cnt = 0, i_done_cnt = 0, wr_cnt = 0;
    logic [15:0] salt;
    obs_t        exp_q [64];
    logic        mv_q [16];
    logic [15:0] md_q [16];

    function automatic logic [15:0] mdata(input logic [15:0] a);
        return a ^ salt;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.mem_en = mem_en;       o.mem_wr = mem_wr;
        o.mem_addr = mem_addr;   o.mem_wdata = mem_wdata;
        o.i_we = i_fill_we;      o.i_grant = i_fill_grant; o.i_done = i_fill_done;
        o.d_we = d_fill_we;      o.d_grant = d_fill_grant; o.d_done = d_fill_done;
        o.wr_done = d_wr_done;   o.word = fill_word;       o.data = fill_data;
        return o;
    endfunction

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: read sampled in cycle c returns in cycle c+lat.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            mem_valid = mv_q[cyc % 16];
            mem_rdata = mv_q[cyc % 16] ? md_q[cyc % 16] : 16'h0;
            mv_q[cyc % 16] = 1'b0;
        end else begin
            mem_valid = 1'b0;
            mem_rdata = 16'h0;
        end
    end

    always @(negedge rst_n) begin
        mem_valid = 1'b0;
        mem_rdata = 16'h0;
        for (int k = 0; k < 16; k++) mv_q[k] = 1'b0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) mv_q[k] = 1'b0;
        end else if (mem_en && !mem_wr) begin
            mv_q[(cyc + lat) % 16] = 1'b1;
            md_q[(cyc + lat) % 16] = mdata(mem_addr);
        end
    end

    // Reference model and per-cycle output comparison
    always @(negedge clk) begin
        obs_t        a, e;
        logic        own_d;
        logic [15:0] base;
        int          idx;
        a = sample();
        if (!rst_n) begin
            for (int k = 0; k < 64; k++) exp_q[k] = '0;
            next_arb = cyc + 1;
            check("reset_outputs", 80'(a), 80'd0);
        end else begin
            e = exp_q[cyc % 64];
            exp_q[cyc % 64] = '0;
            if (!e.mem_en) begin a.mem_addr = '0; e.mem_addr = '0; end
            if (!e.mem_wr) begin a.mem_wdata = '0; e.mem_wdata = '0; end
            if (!(e.i_we || e.d_we)) begin
                a.word = '0; e.word = '0; a.data = '0; e.data = '0;
            end
            check("cycle_outputs", 80'(a), 80'(e));
            if (i_fill_we)   i_we_cnt++;
            if (d_fill_we)   d_we_cnt++;
            if (i_fill_done) i_done_cnt++;
            if (d_wr_done)   wr_cnt++;

            if (cyc == next_arb) begin
                if (d_wr) begin
                    e = '0;
                    e.mem_en = 1'b1; e.mem_wr = 1'b1; e.wr_done = 1'b1;
                    e.mem_addr = d_wr_addr; e.mem_wdata = d_wr_data;
                    exp_q[(cyc + 1) % 64] = e;
                    next_arb = cyc + 3;
                end else if (d_miss || i_miss) begin
                    own_d = d_miss;
                    base  = (d_miss ? d_miss_addr : i_miss_addr) & 16'hFFF0;
                    for (int t = 1; t <= 8 + lat; t++) begin
                        if (own_d) exp_q[(cyc + t) % 64].d_grant = 1'b1;
                        else       exp_q[(cyc + t) % 64].i_grant = 1'b1;
                    end
                    for (int k = 0; k < 8; k++) begin
                        exp_q[(cyc + 1 + k) % 64].mem_en   = 1'b1;
                        exp_q[(cyc + 1 + k) % 64].mem_addr = base + 16'(2 * k);
                        idx = (cyc + 1 + k + lat) % 64;
                        if (own_d) exp_q[idx].d_we = 1'b1;
                        else       exp_q[idx].i_we = 1'b1;
                        exp_q[idx].word = 3'(k);
                        exp_q[idx].data = mdata(base + 16'(2 * k));
                    end
                    if (own_d) exp_q[(cyc + 8 + lat) % 64].d_done = 1'b1;
                    else       exp_q[(cyc + 8 + lat) % 64].i_done = 1'b1;
                    next_arb = cyc + 10 + lat;
                end else begin
                    next_arb = cyc + 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 60 && next_arb > cyc; n++) step();
        check("drain_idle", 80'(next_arb <= cyc), 80'd1);
    endtask

    // sel: 0 i_fill_done, 1 d_fill_done, 2 d_wr_done, 3 i_fill_we
    task automatic wait_evt(input int sel, input int maxc, input string tag, output int at);
        bit hit;
        hit = 1'b0;
        at  = -1;
        for (int n = 0; n < maxc && !hit; n++) begin
            @(negedge clk);
            case (sel)
                0:       hit = i_fill_done;
                1:       hit = d_fill_done;
                2:       hit = d_wr_done;
                default: hit = i_fill_we;
            endcase
            if (hit) at = cyc;
        end
        check({tag, "_seen"}, 80'(hit), 80'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, at, at2, c0, c1;
        bit di, dd, dw;
        rst_n = 1'b0;
        i_miss = 1'b0; d_miss = 1'b0; d_wr = 1'b0;
        i_miss_addr = '0; d_miss_addr = '0; d_wr_addr = '0; d_wr_data = '0;
        mem_valid = 1'b0; mem_rdata = '0;
        salt = 16'($urandom);
        repeat (3) step();
        check("reset_state", 80'(sample()), 80'd0);
        rst_n = 1'b1;

        // Single I-fill, line 0x1230
        drain(); lat = 4; t0 = cyc; c0 = i_we_cnt;
        i_miss_addr = 16'h1236; i_miss = 1'b1;
        wait_evt(0, 40, "t1_done", at);
        check("t1_done_lat", 80'(at - t0), 80'(8 + lat));
        step(); i_miss = 1'b0;
        check("t1_we_count", 80'(i_we_cnt - c0), 80'd8);

        // Simultaneous misses: D first, then I
        drain(); t0 = cyc; c0 = i_we_cnt;
        i_miss_addr = 16'h0040; d_miss_addr = 16'h8000; i_miss = 1'b1; d_miss = 1'b1;
        wait_evt(1, 40, "t2_d_done", at);
        check("t2_d_lat", 80'(at - t0), 80'(8 + lat));
        step(); d_miss = 1'b0;
        check("t2_no_i_we_in_d", 80'(i_we_cnt - c0), 80'd0);
        wait_evt(0, 40, "t2_i_done", at2);
        check("t2_i_lat", 80'(at2 - t0), 80'(18 + 2 * lat));
        step(); i_miss = 1'b0;

        // Write raised at F3 waits for fill completion and GAP
        drain(); t0 = cyc; c0 = wr_cnt;
        d_miss_addr = 16'h4456; d_miss = 1'b1;
        repeat (4) step();
        d_wr_addr = 16'h2002; d_wr_data = 16'hBEEF; d_wr = 1'b1;
        wait_evt(1, 40, "t3_d_done", at);
        step(); d_miss = 1'b0;
        check("t3_wr_held", 80'(wr_cnt - c0), 80'd0);
        wait_evt(2, 10, "t3_wr", at2);
        check("t3_wr_lat", 80'(at2 - at), 80'd3);
        step(); d_wr = 1'b0;

        // Write beats a simultaneous D miss
        drain(); t0 = cyc;
        d_wr_addr = 16'h3004; d_wr_data = 16'h1234; d_wr = 1'b1;
        d_miss_addr = 16'h5A50; d_miss = 1'b1;
        wait_evt(2, 10, "t4_wr", at);
        check("t4_wr_lat", 80'(at - t0), 80'd1);
        step(); d_wr = 1'b0;
        wait_evt(1, 40, "t4_d_done", at2);
        check("t4_d_lat", 80'(at2 - t0), 80'(11 + lat));
        step(); d_miss = 1'b0;

        // Reset at F6 aborts the fill; next fill restarts at word 0
        drain(); t0 = cyc; c0 = i_done_cnt;
        i_miss_addr = 16'h0A00; i_miss = 1'b1;
        repeat (7) step();
        rst_n = 1'b0;
        #1;
        check("t5_reset_now", 80'(sample()), 80'd0);
        i_miss = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        check("t5_no_done", 80'(i_done_cnt - c0), 80'd0);
        drain(); t0 = cyc;
        i_miss_addr = 16'h0A08; i_miss = 1'b1;
        wait_evt(3, 20, "t5_first_we", at);
        check("t5_first_word", 80'(fill_word), 80'd0);
        check("t5_first_lat", 80'(at - t0), 80'(1 + lat));
        wait_evt(0, 20, "t5_done", at);
        step(); i_miss = 1'b0;

        // Miss dropped at F2 still completes; latency sweep 1 and 8
        for (int s = 0; s < 2; s++) begin
            drain(); lat = (s == 0) ? 1 : 8; t0 = cyc; c0 = i_we_cnt;
            i_miss_addr = 16'($urandom); i_miss = 1'b1;
            repeat (3) step();
            i_miss = 1'b0;
            wait_evt(0, 40, "t6_done", at);
            check("t6_done_lat", 80'(at - t0), 80'(8 + lat));
            step();
            check("t6_we_count", 80'(i_we_cnt - c0), 80'd8);
        end

        // Randomized traffic at random memory latencies
        for (int b = 0; b < 4; b++) begin
            drain(); lat = int'($urandom_range(8, 1));
            c0 = i_we_cnt + d_we_cnt; c1 = wr_cnt;
            for (int n = 0; n < 400; n++) begin
                @(negedge clk);
                di = i_fill_done; dd = d_fill_done; dw = d_wr_done;
                step();
                if (di) i_miss = 1'b0;
                else if (!i_miss && n < 300 && $urandom_range(3, 0) == 0) begin
                    i_miss_addr = 16'($urandom); i_miss = 1'b1;
                end else if (i_miss && $urandom_range(15, 0) == 0) i_miss_addr = 16'($urandom);
                if (dd) d_miss = 1'b0;
                else if (!d_miss && n < 300 && $urandom_range(3, 0) == 0) begin
                    d_miss_addr = 16'($urandom); d_miss = 1'b1;
                end else if (d_miss && $urandom_range(15, 0) == 0) d_miss_addr = 16'($urandom);
                if (dw) d_wr = 1'b0;
                else if (!d_wr && n < 300 && $urandom_range(7, 0) == 0) begin
                    d_wr_addr = 16'($urandom); d_wr_data = 16'($urandom); d_wr = 1'b1;
                end
            end
            check("rand_quiet", 80'({i_miss, d_miss, d_wr}), 80'd0);
            check("rand_words_mod8", 80'((i_we_cnt + d_we_cnt - c0) % 8), 80'd0);
        end

        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
